// File: rtl/freq_meter.sv
// Gated edge-count frequency meter: rising edges of sig_in over GATE_CYCLES reference
// clocks, reported in Hz. Optional period measurement is built when PERIOD_MEAS_EN is defined.
module freq_meter #(
    parameter int unsigned INPUT_FREQ  = 100_000_000,
    parameter int unsigned GATE_CYCLES = 100_000_000,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 enable,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] freq_hz,
    output logic                 freq_valid,
`ifdef PERIOD_MEAS_EN
    output logic [CNT_WIDTH-1:0] period_cycles,
    output logic                 period_valid,
    output logic                 no_signal,
`endif
    output logic                 overflow
);

    localparam int unsigned SCALE = INPUT_FREQ / GATE_CYCLES;
    localparam int unsigned GW    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned PWIDE = 2 * CNT_WIDTH;

    typedef enum logic {S_IDLE, S_GATE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_edge;
    logic                   w_terminal;
    logic [GW-1:0]          r_gate_cnt;
    logic [CNT_WIDTH-1:0]   r_edge_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_next;
    logic                   r_win_ovf;
    logic                   w_win_ovf_next;
    logic [PWIDE-1:0]       w_prod;
    logic                   w_prod_sat;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        w_terminal = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) w_next = S_GATE;
            end
            S_GATE: begin
                busy = 1'b1;
                if (!enable)                                   w_next = S_IDLE;
                else if (r_gate_cnt == GW'(GATE_CYCLES - 1))   w_terminal = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Count including this cycle's edge so an edge in the terminal cycle joins the closing window.
    always_comb begin
        w_cnt_next     = r_edge_cnt;
        w_win_ovf_next = r_win_ovf;
        if (w_edge) begin
            if (&r_edge_cnt) w_win_ovf_next = 1'b1;
            else             w_cnt_next     = r_edge_cnt + 1'b1;
        end
        w_prod     = PWIDE'(w_cnt_next) * PWIDE'(SCALE);
        w_prod_sat = |w_prod[PWIDE-1:CNT_WIDTH];
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
            freq_hz    <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if ((r_state == S_GATE) && enable) begin
                if (w_terminal) begin
                    r_gate_cnt <= '0;
                    r_edge_cnt <= '0;
                    r_win_ovf  <= 1'b0;
                    freq_valid <= 1'b1;
                    freq_hz    <= w_prod_sat ? '1 : w_prod[CNT_WIDTH-1:0];
                    overflow   <= w_win_ovf_next | w_prod_sat;
                end else begin
                    r_gate_cnt <= r_gate_cnt + 1'b1;
                    r_edge_cnt <= w_cnt_next;
                    r_win_ovf  <= w_win_ovf_next;
                end
            end else begin
                r_gate_cnt <= '0;
                r_edge_cnt <= '0;
                r_win_ovf  <= 1'b0;
            end
        end
    end

`ifdef PERIOD_MEAS_EN
    localparam int unsigned PER_W = $clog2(GATE_CYCLES + 1);

    logic [PER_W-1:0] r_per_cnt;
    logic [PER_W:0]   w_per_len;
    logic             w_per_sat;
    logic             r_armed;

    assign w_per_len = {1'b0, r_per_cnt} + 1'b1;
    assign w_per_sat = (w_per_len >> CNT_WIDTH) != '0;

    // The first edge after enable or a timeout only arms; later edges report the spacing.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            r_per_cnt     <= '0;
            r_armed       <= 1'b0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
            no_signal     <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                r_armed   <= 1'b0;
                r_per_cnt <= '0;
            end else if (w_edge) begin
                if (r_armed) begin
                    period_cycles <= w_per_sat ? '1 : CNT_WIDTH'(w_per_len);
                    period_valid  <= 1'b1;
                end
                r_armed   <= 1'b1;
                no_signal <= 1'b0;
                r_per_cnt <= '0;
            end else if (r_armed) begin
                if (r_per_cnt == PER_W'(GATE_CYCLES - 1)) begin
                    no_signal <= 1'b1;
                    r_armed   <= 1'b0;
                    r_per_cnt <= '0;
                end else begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: a 32-bit and an 8-bit instance share stimulus and are checked
// against a window/edge-list reference model.
module tb_freq_meter;

    localparam int G   = 1000;
    localparam int SC  = 100;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sig_in = 1'b0;
    logic        enable = 1'b0;
    logic        busy32, fv32, ov32, busy8, fv8, ov8;
    logic [31:0] hz32;
    logic [7:0]  hz8;
`ifdef PERIOD_MEAS_EN
    logic [31:0] pc32;
    logic [7:0]  pc8;
    logic        pv32, ns32, pv8, ns8;
    int          nr, npv, pv_bad;
`endif

    always #5 clk = ~clk;

    freq_meter #(.INPUT_FREQ(100_000), .GATE_CYCLES(G), .CNT_WIDTH(32), .SYNC_STAGES(2)) dut32 (
        .clk_100mhz(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .busy(busy32), .freq_hz(hz32), .freq_valid(fv32),
`ifdef PERIOD_MEAS_EN
        .period_cycles(pc32), .period_valid(pv32), .no_signal(ns32),
`endif
        .overflow(ov32)
    );

    freq_meter #(.INPUT_FREQ(100_000), .GATE_CYCLES(G), .CNT_WIDTH(8), .SYNC_STAGES(2)) dut8 (
        .clk_100mhz(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .busy(busy8), .freq_hz(hz8), .freq_valid(fv8),
`ifdef PERIOD_MEAS_EN
        .period_cycles(pc8), .period_valid(pv8), .no_signal(ns8),
`endif
        .overflow(ov8)
    );

    int cyc = 0, ws = -1, a_drop = -1;
    int mode = 0, per = 100, ph = 0, rise_at = 0;
    bit prev_sig = 1'b0;
    int edges[$];
    int exp_hz32 = 0, exp_hz8 = 0;
    bit exp_ov32 = 1'b0, exp_ov8 = 1'b0;
    int n_total = 0, n_pass = 0, n_fail = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Each call advances n periods: check outputs of the period, then drive sig_in for it.
    task automatic run(input int n);
        int cnt;
        bit eb, ev, s;
        for (int i = 0; i < n; i++) begin
            step();
            eb = (ws >= 0) && (cyc >= ws) && (a_drop < 0 || cyc <= a_drop);
            ev = (ws >= 0) && (cyc > ws) && ((cyc - ws) % G == 0) && (a_drop < 0 || cyc - 1 < a_drop);
            if (ev) begin
                cnt = 0;
                foreach (edges[j]) if (edges[j] >= cyc - G && edges[j] < cyc) cnt++;
                while (edges.size() > 0 && edges[0] < cyc) void'(edges.pop_front());
                exp_hz32 = cnt * SC;
                exp_ov32 = 1'b0;
                exp_hz8  = (cnt * SC > 255) ? 255 : cnt * SC;
                exp_ov8  = (cnt * SC > 255);
                chk("hz32", hz32, exp_hz32);
                chk("ovf32", ov32, exp_ov32);
                chk("hz8", hz8, exp_hz8);
                chk("ovf8", ov8, exp_ov8);
            end
            if (busy32 !== eb || busy8 !== eb || fv32 !== ev || fv8 !== ev ||
                hz32 !== 32'(exp_hz32) || hz8 !== 8'(exp_hz8) ||
                ov32 !== exp_ov32 || ov8 !== exp_ov8) bad++;
`ifdef PERIOD_MEAS_EN
            if (pv32 === 1'b1) begin
                npv++;
                if (pc32 !== 32'(per)) pv_bad++;
            end
`endif
            case (mode)
                1:       s = ((cyc + ph) % per) < (per / 2);
                2:       s = (cyc >= rise_at) && (cyc < rise_at + 5);
                default: s = 1'b0;
            endcase
            if (s && !prev_sig) begin
                edges.push_back(cyc + LAT);
`ifdef PERIOD_MEAS_EN
                nr++;
`endif
            end
            prev_sig = s;
            sig_in   = s;
        end
        chk("cycle_trace", bad, 0);
        bad = 0;
    endtask

    initial begin
        int t;
        repeat (3) step();
        chk("rst_busy", busy32, 0);
        chk("rst_hz", hz32, 0);
        chk("rst_valid", fv32, 0);
        chk("rst_ovf", ov32, 0);
        rst = 1'b0;
        run(4);

        // 1 kHz input, first edge 50 cycles into the window
        enable = 1'b1; ws = cyc + 1; a_drop = -1;
        mode = 1; per = 100; ph = (100 - (ws + 48) % 100) % 100;
        run(3 * G + 1);
        chk("hz_1khz", hz32, 1000);
        chk("ovf_1khz", ov32, 0);

        // abort at gate count 600
        run((600 - (cyc - ws) % G + G) % G);
        enable = 1'b0; a_drop = cyc;
        run(1);
        chk("abort_busy", busy32, 0);
        run(G + 200);
        chk("abort_hold_hz", hz32, 1000);
        chk("abort_idle", busy32, 0);

        // randomized rates, including edge-count and product saturation on the 8-bit unit
        enable = 1'b1; ws = cyc + 1; a_drop = -1;
        for (int w = 0; w < 12; w++) begin
            per = (w == 0) ? 2 : (w == 1) ? 30 : int'($urandom_range(3, 600));
            ph  = int'($urandom_range(0, 999));
            run(G);
        end

        // single edge landing in the terminal gate cycle
        t = cyc + (G - 1 - (cyc - ws) % G) + 2 * G;
        rise_at = t - LAT; mode = 2;
        run(t + 1 - cyc);
        chk("boundary_valid", fv32, 1);
        chk("boundary_hz", hz32, 100);
        run(G);
        chk("boundary_next_hz", hz32, 0);

        // asynchronous reset in the middle of a window with edges present
        mode = 1; per = 50; ph = 0;
        run(G + 300);
        #2 rst = 1'b1;
        #1;
        chk("midrst_hz32", hz32, 0);
        chk("midrst_hz8", hz8, 0);
        chk("midrst_busy", busy32, 0);
        chk("midrst_valid", fv32, 0);
        chk("midrst_ovf", ov8, 0);
        sig_in = 1'b0; prev_sig = 1'b0; mode = 0; enable = 1'b0;
        ws = -1; a_drop = -1; edges.delete();
        exp_hz32 = 0; exp_hz8 = 0; exp_ov32 = 1'b0; exp_ov8 = 1'b0;
        step();
        step();
        rst = 1'b0;
        run(5);
        chk("post_rst_busy", busy32, 0);

`ifdef PERIOD_MEAS_EN
        enable = 1'b1; ws = cyc + 1; a_drop = -1;
        mode = 1; per = 100; ph = 0; nr = 0; npv = 0; pv_bad = 0;
        run(G);
        mode = 0;
        run(20);
        chk("per_pulses", npv, nr - 1);
        chk("per_value", pv_bad, 0);
        chk("nosig_clear", ns32, 0);
        run(G + 20);
        chk("nosig_set", ns32, 1);
        nr = 0; npv = 0; mode = 1;
        run(G);
        chk("nosig_rearm", ns32, 0);
        mode = 0;
        run(20);
        chk("per_pulses_rearm", npv, nr - 1);
        chk("per_value_rearm", pv_bad, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
